// File: rtl/cdc_pkg.sv
// Shared types and constants for the clock-domain-crossing handshake blocks.
package cdc_pkg;

  // Receiver handshake state: waiting for a request, or holding ack high.
  typedef enum logic {HS_RX_IDLE, HS_RX_ACK_HI} hs_rx_state_t;

  // A single flop is not a synchronizer; two stages is the minimum depth.
  localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-stage flop synchronizer for level signals entering this clock domain.
// The chain is tagged ASYNC_REG so placement keeps the stages together.
module cdc_bit_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain_reg [STAGES];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // First stage samples the asynchronous input directly.
      always_ff @(posedge clk) begin
        if (srst) chain_reg[gi] <= '0;
        else      chain_reg[gi] <= d;
      end
    end else begin : g_next
      // Later stages give metastability time to resolve.
      always_ff @(posedge clk) begin
        if (srst) chain_reg[gi] <= '0;
        else      chain_reg[gi] <= chain_reg[gi-1];
      end
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/cdc_hs_receiver.sv
// Destination side of a 4-phase req/ack handshake: synchronizes req, captures the
// data bundle into a small show-ahead buffer, returns ack, and streams words out
// with valid/ready backpressure. A full buffer withholds ack so the source stalls.
// Optional build macro CDC_HS_RX_PARITY_EN adds an even-parity check on capture
// (ports async_par / par_err, par_err sticky until reset).
module cdc_hs_receiver
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                          dst_clk,
  input  logic                          dst_rst,
  input  logic                          async_req,
  input  logic [DATA_WIDTH-1:0]         async_data,
`ifdef CDC_HS_RX_PARITY_EN
  input  logic                          async_par,
  output logic                          par_err,
`endif
  output logic                          async_ack,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("cdc_hs_receiver: SYNC_STAGES must be at least CDC_MIN_SYNC_STAGES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdc_hs_receiver: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic                  req_s;
  hs_rx_state_t          state_reg, state_next;
  logic                  ack_reg, ack_next;
  logic                  push, pop, full;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg;

  // async_req is the only signal crossing in; data is qualified by the synced req.
  cdc_bit_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (dst_clk),
    .srst (dst_rst),
    .d    (async_req),
    .q    (req_s)
  );

  // Full uses the registered level, so a pop in the same cycle does not free a slot.
  always_comb begin
    full = (level_reg == LW'(FIFO_DEPTH));
    pop  = (level_reg != '0) && m_ready;
  end

  // Handshake FSM: one capture per req pulse, ack withheld while the buffer is full.
  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    push       = 1'b0;
    case (state_reg)
      HS_RX_IDLE: begin
        if (req_s && !full) begin
          push       = 1'b1;
          ack_next   = 1'b1;
          state_next = HS_RX_ACK_HI;
        end
      end
      HS_RX_ACK_HI: begin
        if (!req_s) begin
          ack_next   = 1'b0;
          state_next = HS_RX_IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = HS_RX_IDLE;
      end
    endcase
  end

  // State and ack register; ack comes straight from a flop so it cannot glitch.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      state_reg <= HS_RX_IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  // Buffer storage; contents need no reset since m_valid gates them.
  always_ff @(posedge dst_clk) begin
    if (push) mem[wr_ptr_reg] <= async_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef CDC_HS_RX_PARITY_EN
  logic par_err_reg;

  // Even parity over data+parity must be zero; any bad capture latches the flag.
  always_ff @(posedge dst_clk) begin
    if (dst_rst)                             par_err_reg <= 1'b0;
    else if (push && ^{async_data, async_par}) par_err_reg <= 1'b1;
  end

  assign par_err = par_err_reg;
`endif

  assign async_ack = ack_reg;
  assign m_data    = mem[rd_ptr_reg];
  assign m_valid   = (level_reg != '0);
  assign level     = level_reg;
  assign busy      = (state_reg != HS_RX_IDLE) || (level_reg != '0);

endmodule

// File: tb/tb_cdc_hs_receiver.sv
// Bench for cdc_hs_receiver with default parameters. A queue-based model tracks what
// the receiver must hold and whether ack must be high; a compare process checks the
// outputs against it every cycle, and directed tests pin key cycles with literals.
// Define CDC_HS_RX_PARITY_EN to include the parity ports and parity test.
module tb_cdc_hs_receiver;

  localparam int DW    = 32;
  localparam int SYNC  = 2;
  localparam int DEPTH = 2;
  localparam int LIMIT = 200;

  logic          dst_clk;
  logic          dst_rst;
  logic          async_req;
  logic [DW-1:0] async_data;
  logic          async_ack;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    level;
  logic          busy;
`ifdef CDC_HS_RX_PARITY_EN
  logic          async_par;
  logic          par_err;
`endif

  int total = 0;
  int bad   = 0;

  cdc_hs_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .dst_clk    (dst_clk),
    .dst_rst    (dst_rst),
    .async_req  (async_req),
    .async_data (async_data),
`ifdef CDC_HS_RX_PARITY_EN
    .async_par  (async_par),
    .par_err    (par_err),
`endif
    .async_ack  (async_ack),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .busy       (busy)
  );

  initial dst_clk = 1'b0;
  always #5 dst_clk = ~dst_clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", name, act, $time);
    end
  endtask

  task automatic chk_quiet(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge; outputs are settled by then.
  task automatic tick;
    @(posedge dst_clk);
    #2;
  endtask

  task automatic set_word(input logic [DW-1:0] w);
    async_data = w;
`ifdef CDC_HS_RX_PARITY_EN
    async_par = ^w;
`endif
  endtask

  // ---------------- behavioural model ----------------
  // Buffer contents as a plain queue; ack is high from capture until the synced
  // request (request as sampled SYNC edges earlier) is seen low.
  logic [DW-1:0] mq[$];
  bit            m_ack;
  bit            hist[$];
  bit            model_ok = 1'b0;

  always @(posedge dst_clk) begin : model
    bit rs;
    int sz;
    if (dst_rst) begin
      mq.delete();
      m_ack = 1'b0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      model_ok = 1'b1;
    end else if (model_ok) begin
      rs = hist[SYNC-1];
      sz = mq.size();
      if (sz > 0 && m_ready) void'(mq.pop_front());
      if (!m_ack && rs && sz < DEPTH) begin
        mq.push_back(async_data);
        m_ack = 1'b1;
      end else if (m_ack && !rs) begin
        m_ack = 1'b0;
      end
      hist.push_front(async_req);
      void'(hist.pop_back());
    end
  end

  // Every-cycle comparison against the model, plus a log of words consumed.
  logic [DW-1:0] got[$];
  always @(negedge dst_clk) begin
    if (model_ok) begin
      chk_quiet("cyc_ack",   {63'd0, async_ack}, {63'd0, m_ack});
      chk_quiet("cyc_valid", {63'd0, m_valid},   {63'd0, (mq.size() != 0)});
      chk_quiet("cyc_level", {62'd0, level},     64'(mq.size()));
      chk_quiet("cyc_busy",  {63'd0, busy},      {63'd0, (m_ack || mq.size() != 0)});
      if (mq.size() != 0) chk_quiet("cyc_data", {32'd0, m_data}, {32'd0, mq[0]});
      if (m_valid && m_ready) got.push_back(m_data);
    end
  end

  // ---------------- source-side 4-phase sender ----------------
  logic [DW-1:0] sent[$];

  task automatic send(input logic [DW-1:0] w, input int gap);
    int n;
    repeat (gap) tick;
    set_word(w);
    async_req = 1'b1;
    n = 0;
    while (!async_ack && n < 4 * LIMIT) begin tick; n++; end
    if (n >= 4 * LIMIT) chk("ack_rise_timeout", 64'(n), 64'(0));
    async_req = 1'b0;
    n = 0;
    while (async_ack && n < LIMIT) begin tick; n++; end
    if (n >= LIMIT) chk("ack_fall_timeout", 64'(n), 64'(0));
    sent.push_back(w);
    $display("sent word %h", w);
  endtask

  task automatic check_order(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      chk_quiet({name, "_word"}, {32'd0, got[i]}, {32'd0, sent[i]});
  endtask

  bit rnd_ready_en = 1'b0;
  initial begin
    forever begin
      tick;
      if (rnd_ready_en) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  bit snd_done;

  // ---------------- directed tests ----------------
  initial begin
    dst_rst   = 1'b1;
    async_req = 1'b0;
    m_ready   = 1'b0;
    set_word('0);
    repeat (3) tick;
    dst_rst = 1'b0;
    chk("rst_ack",   {63'd0, async_ack}, 64'd0);
    chk("rst_valid", {63'd0, m_valid},   64'd0);
    chk("rst_level", {62'd0, level},     64'd0);
    chk("rst_busy",  {63'd0, busy},      64'd0);

    // Test 1: single word latency and ack release timing.
    m_ready = 1'b1;
    set_word(32'hDEAD_BEEF);
    async_req = 1'b1;
    tick; tick;
    chk("t1_ack_edge1", {63'd0, async_ack}, 64'd0);
    tick;
    chk("t1_ack_edge2",   {63'd0, async_ack}, 64'd1);
    chk("t1_valid_edge2", {63'd0, m_valid},   64'd1);
    chk("t1_data_edge2",  {32'd0, m_data},    64'hDEAD_BEEF);
    tick;
    chk("t1_popped_level", {62'd0, level}, 64'd0);
    chk("t1_ack_held",     {63'd0, async_ack}, 64'd1);
    async_req = 1'b0;
    tick; tick;
    chk("t1_ack_edge1_after_drop", {63'd0, async_ack}, 64'd1);
    tick;
    chk("t1_ack_edge2_after_drop", {63'd0, async_ack}, 64'd0);
    repeat (3) tick;

    // Test 2: backpressure stalls the third word; order preserved.
    got.delete(); sent.delete();
    m_ready = 1'b0;
    snd_done = 1'b0;
    fork
      begin
        send(32'hA1A1_0001, 0);
        send(32'hA2A2_0002, 0);
        send(32'hA3A3_0003, 0);
        snd_done = 1'b1;
      end
    join_none
    repeat (30) tick;
    chk("t2_level_full", {62'd0, level},     64'd2);
    chk("t2_ack_stall",  {63'd0, async_ack}, 64'd0);
    chk("t2_head",       {32'd0, m_data},    64'hA1A1_0001);
    m_ready = 1'b1;
    for (int i = 0; i < LIMIT && !snd_done; i++) tick;
    chk("t2_sender_done", {63'd0, snd_done}, 64'd1);
    repeat (5) tick;
    check_order("t2_order");

    // Test 3: pop on a full buffer blocks capture for that one cycle.
    got.delete(); sent.delete();
    m_ready = 1'b0;
    snd_done = 1'b0;
    fork
      begin
        send(32'hB0B0_0001, 0);
        send(32'hB0B0_0002, 0);
        send(32'hB0B0_0003, 0);
        snd_done = 1'b1;
      end
    join_none
    repeat (30) tick;
    chk("t3_level_full", {62'd0, level}, 64'd2);
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk("t3_level_after_pop", {62'd0, level},     64'd1);
    chk("t3_no_capture",      {63'd0, async_ack}, 64'd0);
    tick;
    chk("t3_level_recapture", {62'd0, level},     64'd2);
    chk("t3_ack_capture",     {63'd0, async_ack}, 64'd1);
    m_ready = 1'b1;
    for (int i = 0; i < LIMIT && !snd_done; i++) tick;
    chk("t3_sender_done", {63'd0, snd_done}, 64'd1);
    repeat (5) tick;
    check_order("t3_order");

    // Test 4: reset while ack is high with one word buffered; req still high.
    m_ready = 1'b0;
    set_word(32'hC0DE_0004);
    async_req = 1'b1;
    repeat (4) tick;
    chk("t4_ack_before", {63'd0, async_ack}, 64'd1);
    chk("t4_level_before", {62'd0, level}, 64'd1);
    dst_rst = 1'b1;
    tick;
    dst_rst = 1'b0;
    chk("t4_rst_ack",   {63'd0, async_ack}, 64'd0);
    chk("t4_rst_valid", {63'd0, m_valid},   64'd0);
    chk("t4_rst_level", {62'd0, level},     64'd0);
    chk("t4_rst_busy",  {63'd0, busy},      64'd0);
    tick; tick;
    chk("t4_ack_edge1", {63'd0, async_ack}, 64'd0);
    tick;
    chk("t4_recapture_ack",  {63'd0, async_ack}, 64'd1);
    chk("t4_recapture_data", {32'd0, m_data},    64'hC0DE_0004);
    async_req = 1'b0;
    m_ready   = 1'b1;
    repeat (6) tick;

    // Test 5: random word stream, random gaps, random consumer readiness.
    got.delete(); sent.delete();
    rnd_ready_en = 1'b1;
    for (int i = 0; i < 60; i++) send($urandom, $urandom_range(0, 6));
    rnd_ready_en = 1'b0;
    m_ready = 1'b1;
    repeat (8) tick;
    check_order("t5_stream");

`ifdef CDC_HS_RX_PARITY_EN
    // Test 6: a bad-parity word sets a sticky flag that only reset clears.
    chk("t6_par_clear", {63'd0, par_err}, 64'd0);
    async_data = 32'h1;
    async_par  = 1'b0;
    async_req  = 1'b1;
    repeat (4) tick;
    async_req = 1'b0;
    repeat (4) tick;
    chk("t6_par_set", {63'd0, par_err}, 64'd1);
    send(32'h0000_0003, 0);
    repeat (3) tick;
    chk("t6_par_sticky", {63'd0, par_err}, 64'd1);
    dst_rst = 1'b1;
    tick;
    dst_rst = 1'b0;
    chk("t6_par_reset", {63'd0, par_err}, 64'd0);
`endif

    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
